// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmem_arbiter
// Description : Merges the I-cache (a) and D-cache (b) pmem ports onto one
//               single-ported physical-memory initiator, round-robin on
//               contention, one transaction in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read_a,
  input  logic              pmem_write_a,
  input  logic [ADDR_W-1:0] pmem_address_a,
  input  logic [LINE_W-1:0] pmem_wdata_a,
  output logic              pmem_resp_a,
  output logic [LINE_W-1:0] pmem_rdata_a,
  input  logic              pmem_read_b,
  input  logic              pmem_write_b,
  input  logic [ADDR_W-1:0] pmem_address_b,
  input  logic [LINE_W-1:0] pmem_wdata_b,
  output logic              pmem_resp_b,
  output logic [LINE_W-1:0] pmem_rdata_b,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic C_PORT_A = 1'b0;
  localparam logic C_PORT_B = 1'b1;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              resp_a_q, resp_a_d;
  logic              resp_b_q, resp_b_d;
  logic [LINE_W-1:0] rdata_a_q, rdata_a_d;
  logic [LINE_W-1:0] rdata_b_q, rdata_b_d;

  logic w_req_a;
  logic w_req_b;
  logic w_pick_b;

  assign w_req_a  = pmem_read_a | pmem_write_a;
  assign w_req_b  = pmem_read_b | pmem_write_b;
  // b wins when it is alone, or when both ask and a was served last
  assign w_pick_b = w_req_b & (~w_req_a | (last_q == C_PORT_A));

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    resp_a_d      = 1'b0;
    resp_b_d      = 1'b0;
    rdata_a_d     = rdata_a_q;
    rdata_b_d     = rdata_b_q;

    case (state_q)
      S_IDLE: begin
        if (w_req_a | w_req_b) begin
          gnt_d = w_pick_b;
          // write takes priority if an initiator raises both strobes
          if (w_pick_b) begin
            mem_write_d   = pmem_write_b;
            mem_read_d    = ~pmem_write_b;
            mem_address_d = pmem_address_b;
            mem_wdata_d   = pmem_wdata_b;
          end else begin
            mem_write_d   = pmem_write_a;
            mem_read_d    = ~pmem_write_a;
            mem_address_d = pmem_address_a;
            mem_wdata_d   = pmem_wdata_a;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          last_d      = gnt_q;
          if (gnt_q == C_PORT_B) begin
            rdata_b_d = mem_rdata;
            resp_b_d  = 1'b1;
          end else begin
            rdata_a_d = mem_rdata;
            resp_a_d  = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_q        <= C_PORT_B;
      gnt_q         <= C_PORT_A;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      resp_a_q      <= 1'b0;
      resp_b_q      <= 1'b0;
      rdata_a_q     <= '0;
      rdata_b_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      resp_a_q      <= resp_a_d;
      resp_b_q      <= resp_b_d;
      rdata_a_q     <= rdata_a_d;
      rdata_b_q     <= rdata_b_d;
    end
  end

  assign pmem_resp_a  = resp_a_q;
  assign pmem_resp_b  = resp_b_q;
  assign pmem_rdata_a = rdata_a_q;
  assign pmem_rdata_b = rdata_b_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_address  = mem_address_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
`default_nettype wire
